// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator sequencer: FSM state encoding and RUN watchdog limit.
package cfg_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READ,
        FINISH
    } seq_state_t;

    localparam logic [15:0] SEQ_TIMEOUT_CYCLES = 16'hFFFF;

endpackage

// File: rtl/seq_out_reg.sv
// Single-entry result register with valid/ready handshake; data holds while stalled.
module seq_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// Load -> run -> read-back sequencer sharing one memory port with an accelerator.
// Optional RUN watchdog enabled by defining ACCEL_SEQ_TIMEOUT_EN.
module accel_sequencer
    import cfg_types_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go,
    input  logic [MEM_ADDR_WIDTH:0]     wr_cnt,
    input  logic [MEM_ADDR_WIDTH-1:0]   rd_base,
    input  logic [MEM_ADDR_WIDTH:0]     rd_cnt,
    input  logic [7:0]                  cfg_max_cnt,
    input  logic [7:0]                  cfg_incr,
    output logic                        busy,
    output logic                        seq_done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MEM_DATA_WIDTH-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MEM_DATA_WIDTH-1:0]   out_data,
    output logic                        start,
    input  logic                        done,
    output logic [7:0]                  max_cnt,
    output logic [7:0]                  incr,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
    output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
    output logic                        timeout
);

    localparam int CW = MEM_ADDR_WIDTH + 1;

    seq_state_t                state, state_nxt;
    logic [CW-1:0]             wr_cnt_q, rd_cnt_q, ld_idx, rd_idx;
    logic [MEM_ADDR_WIDTH-1:0] rd_base_q;
    logic                      rd_vld_p1;
    logic                      go_acc, wr_fire, rd_fire, out_acc, rd_last, run_to;

    function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
        return (c > CW'(MEM_DEPTH)) ? CW'(MEM_DEPTH) : c;
    endfunction

    assign go_acc  = go && (state == IDLE);
    assign wr_fire = (state == LOAD) && in_valid;
    assign out_acc = out_valid && out_ready;
    // One read in flight at most, and only into a register that is empty or draining.
    assign rd_fire = (state == READ) && !rd_vld_p1 && (rd_idx != rd_cnt_q)
                     && (!out_valid || out_ready);
    assign rd_last = out_acc && !rd_vld_p1 && (rd_idx == rd_cnt_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (go) state_nxt = (wr_cnt == '0) ? RUN : LOAD;
            LOAD:   if (wr_fire && (ld_idx + CW'(1) == wr_cnt_q)) state_nxt = RUN;
            RUN: begin
                if (run_to)    state_nxt = FINISH;
                else if (done) state_nxt = (rd_cnt_q == '0) ? FINISH : READ;
            end
            READ:   if (rd_last) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        seq_done  = (state == FINISH);
        in_ready  = (state == LOAD);
        start     = (state == RUN);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_fire) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = ld_idx[MEM_ADDR_WIDTH-1:0];
            mem_wdata = in_data;
        end else if (rd_fire) begin
            mem_en    = 1'b1;
            mem_addr  = rd_base_q + rd_idx[MEM_ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_base_q <= '0;
            ld_idx    <= '0;
            rd_idx    <= '0;
            rd_vld_p1 <= 1'b0;
            max_cnt   <= '0;
            incr      <= '0;
        end else begin
            state     <= state_nxt;
            rd_vld_p1 <= rd_fire;
            if (go_acc) begin
                wr_cnt_q  <= clamp_cnt(wr_cnt);
                rd_cnt_q  <= clamp_cnt(rd_cnt);
                rd_base_q <= rd_base;
                max_cnt   <= cfg_max_cnt;
                incr      <= cfg_incr;
                ld_idx    <= '0;
                rd_idx    <= '0;
            end else begin
                if (wr_fire) ld_idx <= ld_idx + CW'(1);
                if (rd_fire) rd_idx <= rd_idx + CW'(1);
            end
        end
    end

`ifdef ACCEL_SEQ_TIMEOUT_EN
    logic [15:0] run_cnt;

    // run_cnt holds completed RUN cycles; the exit edge is the one where it reaches FFFF.
    assign run_to = (state == RUN) && (run_cnt == SEQ_TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            run_cnt <= (state == RUN) ? run_cnt + 16'd1 : '0;
            if (go_acc)      timeout <= 1'b0;
            else if (run_to) timeout <= 1'b1;
        end
    end
`else
    assign run_to  = 1'b0;
    assign timeout = 1'b0;
`endif

    seq_out_reg #(
        .DATA_W(MEM_DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rd_vld_p1),
        .load_data(mem_rdata),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: table of load/run/read sequences plus directed corner cases.
`timescale 1ns/1ps
module tb_accel_sequencer;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            go;
    logic [CW-1:0]   wr_cnt;
    logic [AW-1:0]   rd_base;
    logic [CW-1:0]   rd_cnt;
    logic [7:0]      cfg_max_cnt, cfg_incr;
    logic            busy, seq_done;
    logic            in_valid, in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_data;
    logic            start, done;
    logic [7:0]      max_cnt, incr;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            timeout;

    always #5 clk = ~clk;

    accel_sequencer #(
        .MEM_ADDR_WIDTH(AW),
        .MEM_DATA_WIDTH(DW),
        .MEM_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .wr_cnt     (wr_cnt),
        .rd_base    (rd_base),
        .rd_cnt     (rd_cnt),
        .cfg_max_cnt(cfg_max_cnt),
        .cfg_incr   (cfg_incr),
        .busy       (busy),
        .seq_done   (seq_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .start      (start),
        .done       (done),
        .max_cnt    (max_cnt),
        .incr       (incr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .timeout    (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    function automatic logic [DW-1:0] word(input int v, input int k);
        if (v == 0) return DW'((k + 1) * 'h11);
        return {8'(v), 8'h5A, 16'(k)};
    endfunction

    // Memory model: single port, read data one cycle after the request.
    logic          mem_clr;
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else begin
            if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        end
    end

    logic [DW-1:0]    ref_mem [DEPTH];
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_rd_q[$];

    int               n_mem_en = 0, n_done_pulse = 0, n_results = 0;
    logic             prev_hold = 1'b0, prev_rd = 1'b0;
    logic [DW-1:0]    prev_data = '0;
    logic [AW+DW-1:0] e_wr;
    logic [DW-1:0]    e_rd;

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (mem_en)   n_mem_en++;
            if (seq_done) n_done_pulse++;
            if (mem_en && mem_we) begin
                if (exp_wr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_unexpected: write to 0x%0h, none expected", mem_addr);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    chk("wr_addr", mem_addr, e_wr[AW+DW-1:DW]);
                    chk("wr_data", mem_wdata, e_wr[DW-1:0]);
                    chk("wr_be", mem_be, 4'hF);
                end
            end
            if (start)                    chk("run_mem_en", mem_en, 0);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && !out_ready)  chk("bp_mem_en", mem_en, 0);
            if (prev_rd)                  chk("rd_outstanding", mem_en && !mem_we, 0);
            if (out_valid && out_ready) begin
                n_results++;
                if (exp_rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected: result 0x%0h, none expected", out_data);
                end else begin
                    e_rd = exp_rd_q.pop_front();
                    chk("rd_data", out_data, e_rd);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_rd   = mem_en && !mem_we;
        end else begin
            prev_hold = 1'b0;
            prev_rd   = 1'b0;
        end
    end

    typedef struct {
        int wr;
        int base;
        int rd;
        int dly;
        bit bp;
        int exp_wr;
        int exp_rd;
    } vec_t;

    vec_t vt[5];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_seq_done"}, seq_done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_max_cnt"}, max_cnt, 0);
        chk({tag, "_incr"}, incr, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Called on the first RUN cycle: waits dly cycles, pulses done, drains results.
    task automatic finish_seq(input int dly, input bit bp, input int exp_wr, input int exp_rd,
                              input int en0);
        int d0, res0, cyc, hold;
        d0   = n_done_pulse;
        res0 = n_results;
        chk("start_run", start, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("start_hold", start, 1);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("start_drop", start, 0);
        cyc  = 0;
        hold = 0;
        while (n_done_pulse == d0 && cyc < 5000) begin
            if (bp && out_valid && hold < 3) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) hold = 0;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("seq_done_once", n_done_pulse - d0, 1);
        chk("idle_busy", busy, 0);
        chk("results", n_results - res0, exp_rd);
        chk("rd_q_empty", exp_rd_q.size(), 0);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        chk("mem_en_count", n_mem_en - en0, exp_wr + exp_rd);
        chk("timeout_low", timeout, 0);
    endtask

    task automatic run_vec(input int v);
        vec_t c;
        int   k, cyc, en0;
        c   = vt[v];
        en0 = n_mem_en;
        @(negedge clk);
        go          = 1'b1;
        wr_cnt      = CW'(c.wr);
        rd_base     = AW'(c.base);
        rd_cnt      = CW'(c.rd);
        cfg_max_cnt = 8'(v * 3 + 7);
        cfg_incr    = 8'(v + 1);
        for (int i = 0; i < c.exp_wr; i++) ref_mem[i % DEPTH] = word(v, i);
        for (int i = 0; i < c.exp_rd; i++) exp_rd_q.push_back(ref_mem[(c.base + i) % DEPTH]);
        @(negedge clk);
        go = 1'b0;
        chk("busy_go", busy, 1);
        chk("max_cnt", max_cnt, 8'(v * 3 + 7));
        chk("incr", incr, 8'(v + 1));
        k   = 0;
        cyc = 0;
        while (k < c.exp_wr && cyc < 3000) begin
            in_valid = 1'b1;
            in_data  = word(v, k);
            if (in_ready) begin
                exp_wr_q.push_back({AW'(k), word(v, k)});
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("load_words", k, c.exp_wr);
        chk("load_cycles", cyc, c.exp_wr);
        finish_seq(c.dly, c.bp, c.exp_wr, c.exp_rd, en0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int en0, d0, cyc, run_cyc;

        vt[0] = '{wr: 4,    base: 'h10,  rd: 2,    dly: 5, bp: 1'b0, exp_wr: 4,    exp_rd: 2};
        vt[1] = '{wr: 3,    base: 'h3FE, rd: 4,    dly: 2, bp: 1'b1, exp_wr: 3,    exp_rd: 4};
        vt[2] = '{wr: 0,    base: 0,     rd: 0,    dly: 1, bp: 1'b0, exp_wr: 0,    exp_rd: 0};
        vt[3] = '{wr: 2047, base: 0,     rd: 3,    dly: 0, bp: 1'b0, exp_wr: 1024, exp_rd: 3};
        vt[4] = '{wr: 1,    base: 5,     rd: 2000, dly: 3, bp: 1'b0, exp_wr: 1,    exp_rd: 1024};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0; mem_clr = 1'b1;
        go = 1'b0; wr_cnt = '0; rd_base = '0; rd_cnt = '0;
        cfg_max_cnt = '0; cfg_incr = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(v);

        // go together with done in IDLE, then go again while busy
        en0 = n_mem_en;
        @(negedge clk);
        go = 1'b1; done = 1'b1; wr_cnt = '0; rd_base = 10'd7; rd_cnt = 11'd1;
        cfg_max_cnt = 8'h3C; cfg_incr = 8'h05;
        exp_rd_q.push_back(ref_mem[7]);
        @(negedge clk);
        go = 1'b0; done = 1'b0;
        chk("go_done_run", start, 1);
        go = 1'b1; wr_cnt = 11'd5; rd_cnt = '0; cfg_max_cnt = 8'hEE;
        @(negedge clk);
        go = 1'b0;
        chk("busy_go_start", start, 1);
        chk("busy_go_max_cnt", max_cnt, 8'h3C);
        finish_seq(2, 1'b0, 0, 1, en0);

        // reset while a result waits in the output register
        @(negedge clk);
        go = 1'b1; wr_cnt = '0; rd_base = 10'h20; rd_cnt = 11'd3;
        @(negedge clk);
        go = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        cyc  = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

`ifdef ACCEL_SEQ_TIMEOUT_EN
        en0 = n_mem_en;
        d0  = n_done_pulse;
        @(negedge clk);
        go = 1'b1; wr_cnt = '0; rd_base = '0; rd_cnt = 11'd4;
        @(negedge clk);
        go      = 1'b0;
        cyc     = 0;
        run_cyc = 0;
        while (n_done_pulse == d0 && cyc < 70000) begin
            if (start) run_cyc++;
            @(negedge clk);
            cyc++;
        end
        chk("to_run_cycles", run_cyc, 65535);
        chk("to_flag", timeout, 1);
        chk("to_seq_done", n_done_pulse - d0, 1);
        chk("to_no_mem", n_mem_en - en0, 0);
        chk("to_busy", busy, 0);
        @(negedge clk);
        go = 1'b1; wr_cnt = '0; rd_cnt = '0;
        @(negedge clk);
        go = 1'b0;
        chk("to_clear_on_go", timeout, 0);
        finish_seq(1, 1'b0, 0, 0, n_mem_en);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_sequencer.md
ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameters SHALL be: MEM_ADDR_WIDTH, 10, word address width; MEM_DATA_WIDTH, 32, data width; MEM_DEPTH, 1024, memory words.
REQ-002 Ports SHALL be:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
go  in  1  one-cycle pulse starting a sequence; ignored unless idle
wr_cnt  in  MEM_ADDR_WIDTH+1  words to load at address 0
rd_base  in  MEM_ADDR_WIDTH  first result address
rd_cnt  in  MEM_ADDR_WIDTH+1  result words to read
cfg_max_cnt  in  8  forwarded to the accelerator
cfg_incr  in  8  forwarded to the accelerator
busy  out  1  high while not IDLE
seq_done  out  1  one-cycle pulse at sequence end
in_valid / in_ready / in_data  in / out / in  1/1/MEM_DATA_WIDTH  load stream
out_valid / out_ready / out_data  out / in / out  1/1/MEM_DATA_WIDTH  result stream
start  out  1  accelerator start level
done  in  1  accelerator completion
max_cnt, incr  out  8 each  registered copies of cfg_max_cnt, cfg_incr
mem_en, mem_we  out  1 each  memory request, write enable
mem_addr  out  MEM_ADDR_WIDTH  word address
mem_be  out  MEM_DATA_WIDTH/8  byte enables
mem_wdata  out  MEM_DATA_WIDTH  write data
mem_rdata  in  MEM_DATA_WIDTH  read data, valid one cycle after read request
timeout  out  1  sticky watchdog flag (REQ-019)

Function
REQ-003 The block SHALL implement the states IDLE, LOAD, RUN, READ, FINISH.
REQ-004 In IDLE, go SHALL latch wr_cnt, rd_base, rd_cnt, cfg_max_cnt and cfg_incr, and the block SHALL enter LOAD, or RUN if wr_cnt==0.
REQ-005 In LOAD, every in_valid&&in_ready cycle SHALL issue mem_en=1, mem_we=1, mem_be=all ones, mem_wdata=in_data, and mem_addr = load counter starting at 0.
REQ-006 in_ready SHALL be high only in LOAD; the cycle accepting word wr_cnt-1 SHALL move to RUN.
REQ-007 In RUN, start SHALL be held 1, and mem_en, mem_we and mem_be SHALL be 0 because the accelerator then owns the shared port.
REQ-008 In RUN, done sampled high SHALL drop start on the next cycle and move to READ, or to FINISH if rd_cnt==0.
REQ-009 In READ, at most one read SHALL be outstanding: mem_en=1, mem_we=0, mem_addr=rd_base+index, issued only when the output register is empty or is being accepted in that cycle.
REQ-010 Read data SHALL be captured one cycle after the request into the output register, with out_valid=1 held until out_ready.
REQ-011 out_data SHALL remain stable while out_valid&&!out_ready.
REQ-012 After the last result is accepted the block SHALL enter FINISH, pulse seq_done for one cycle and return to IDLE.
REQ-013 mem_addr SHALL wrap modulo 2^MEM_ADDR_WIDTH; counts above MEM_DEPTH SHALL be clamped to MEM_DEPTH at latch time.
REQ-014 go while busy SHALL be ignored; go and done in the same IDLE cycle SHALL honour go only.

Reset
REQ-015 While rst_n=0, all state SHALL clear asynchronously: state=IDLE; start, busy, seq_done, in_ready, out_valid, mem_en, mem_we, timeout=0; mem_be, mem_addr, mem_wdata, out_data, max_cnt, incr=0.
REQ-016 Reset mid-sequence SHALL abandon the transfer; no partial out_valid SHALL survive reset.

Configuration
REQ-017 Macro ACCEL_SEQ_TIMEOUT_EN SHALL select the RUN watchdog.
REQ-018 Without ACCEL_SEQ_TIMEOUT_EN, RUN SHALL wait indefinitely for done, and timeout SHALL be tied to 0.
REQ-019 With ACCEL_SEQ_TIMEOUT_EN, a 16-bit RUN cycle counter reaching 16'hFFFF SHALL drop start, set timeout sticky until the next go, skip READ and enter FINISH.

Structure
REQ-020 The state enum seq_state_t and the constant SEQ_TIMEOUT_CYCLES SHALL live in cfg_types_pkg.
REQ-021 The output register and valid logic SHALL be a sub-module seq_out_reg; the counters and FSM SHALL stay in accel_sequencer.

Verification
REQ-022 Directed scenarios:
- Load 4 words 0x11..0x44 with in_valid held high -> writes to addresses 0..3 on 4 consecutive cycles, then start=1.
- done pulsed 5 cycles into RUN -> start=0 on the next cycle; with rd_base=0x10 and rd_cnt=2, reads 0x10 and 0x11 appear in order on out_data.
- out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and no new mem_en.
- wr_cnt=0, rd_cnt=0 -> IDLE->RUN->FINISH, seq_done pulses once, no mem_en.
- rst_n asserted in READ -> all outputs at reset values immediately; the next go runs normally.
- With ACCEL_SEQ_TIMEOUT_EN and done never asserted -> after 65535 RUN cycles timeout=1, seq_done pulses, no reads issued.
